// File: rtl/phase_controller_if.sv
// ---------------------------------------------------------------------------
// phase_controller_if
// Groups the signals the phase sequencer exchanges with the rest of the core.
//   imem_ready       : instruction memory holds a valid instruction this cycle
//   dmem_ready       : data memory access completes this cycle
//   mem_op           : current instruction is a LOAD or STORE
//   halt_req         : level request to stop at the next instruction boundary
//   phase_fetch ..
//   phase_writeback  : one-hot stage enables
//   halted           : sequencer parked in HALT
//   wait_err         : sticky memory wait timeout
//   cycle_cnt        : cycles spent stepping instructions
//   instret_cnt      : retired instructions
// master = the sequencer, slave = the surrounding core.
// ---------------------------------------------------------------------------
interface phase_controller_if #(
    parameter int CNT_WIDTH = 64
);
    logic                 imem_ready;
    logic                 dmem_ready;
    logic                 mem_op;
    logic                 halt_req;
    logic                 phase_fetch;
    logic                 phase_decode;
    logic                 phase_execute;
    logic                 phase_memory;
    logic                 phase_writeback;
    logic                 halted;
    logic                 wait_err;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [CNT_WIDTH-1:0] instret_cnt;

    modport master (
        input  imem_ready, dmem_ready, mem_op, halt_req,
        output phase_fetch, phase_decode, phase_execute, phase_memory,
               phase_writeback, halted, wait_err, cycle_cnt, instret_cnt
    );

    modport slave (
        output imem_ready, dmem_ready, mem_op, halt_req,
        input  phase_fetch, phase_decode, phase_execute, phase_memory,
               phase_writeback, halted, wait_err, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/phase_controller.sv
// ---------------------------------------------------------------------------
// phase_controller
// Multi-cycle sequencer for the RockWave core. Steps one instruction at a
// time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, producing the
// one-hot stage enables, stalling on memory with a timeout, honouring a halt
// handshake at instruction boundaries and counting cycles/retired
// instructions for the CSR block.
// Ports:
//   clk    : CPU clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : phase_controller_if.master (ready/halt inputs, phase enables,
//            status and counters)
// Parameters:
//   CNT_WIDTH  : width of cycle_cnt / instret_cnt
//   WAIT_LIMIT : consecutive not-ready cycles tolerated before error (>=1)
// ---------------------------------------------------------------------------
module phase_controller #(
    parameter int CNT_WIDTH  = 64,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    phase_controller_if.master  bus
);

    // The wait counter never passes WAIT_LIMIT: reaching it while still
    // stalled forces ERROR, which clears the counter on the state change.
    localparam int              WAIT_W   = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_HALT,
        S_ERROR
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 halted_q;
    logic                 wait_err_q;
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] instret_q;

    logic fetch_stall;
    logic mem_stall;
    logic stall;
    logic timeout;
    logic mem_done;
    logic active;

    // mem_op only matters while in MEMORY; a non-memory instruction passes
    // straight through that stage.
    assign fetch_stall = (state == S_FETCH) && !bus.imem_ready;
    assign mem_stall   = (state == S_MEMORY) && bus.mem_op && !bus.dmem_ready;
    assign mem_done    = !bus.mem_op || bus.dmem_ready;
    assign stall       = fetch_stall || mem_stall;
    assign timeout     = stall && (wait_cnt == WAIT_MAX);
    assign active      = (state == S_FETCH)   || (state == S_DECODE) ||
                         (state == S_EXECUTE) || (state == S_MEMORY) ||
                         (state == S_WRITEBACK);

    // Phase enables are Mealy so a stage's FFs capture in the same cycle
    // its memory reports ready; state is one-hot by construction.
    assign bus.phase_fetch     = (state == S_FETCH) && bus.imem_ready;
    assign bus.phase_decode    = (state == S_DECODE);
    assign bus.phase_execute   = (state == S_EXECUTE);
    assign bus.phase_memory    = (state == S_MEMORY) && mem_done;
    assign bus.phase_writeback = (state == S_WRITEBACK);

    assign bus.halted      = halted_q;
    assign bus.wait_err    = wait_err_q;
    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;

    // Next-state selection. A ready arriving on the limit cycle is checked
    // first, so it wins over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      next_state = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ready)
                    next_state = S_DECODE;
                else if (timeout)
                    next_state = S_ERROR;
            end
            S_DECODE:    next_state = S_EXECUTE;
            S_EXECUTE:   next_state = S_MEMORY;
            S_MEMORY: begin
                if (mem_done)
                    next_state = S_WRITEBACK;
                else if (timeout)
                    next_state = S_ERROR;
            end
            S_WRITEBACK: next_state = bus.halt_req ? S_HALT : S_FETCH;
            S_HALT: begin
                if (!bus.halt_req)
                    next_state = S_FETCH;
            end
            S_ERROR:     next_state = S_ERROR;
            default:     next_state = S_IDLE;
        endcase
    end

    // State, wait counter, status flags and counters. ERROR stops the
    // counters because it is outside the active set and has no writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            halted_q   <= 1'b0;
            wait_err_q <= 1'b0;
            cycle_q    <= '0;
            instret_q  <= '0;
        end else begin
            state    <= next_state;
            halted_q <= (next_state == S_HALT);

            if (next_state != state)
                wait_cnt <= '0;
            else if (stall)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (timeout && (next_state == S_ERROR))
                wait_err_q <= 1'b1;

            if (active)
                cycle_q <= cycle_q + CNT_WIDTH'(1);

            if (bus.phase_writeback)
                instret_q <= instret_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_phase_controller.sv
// ---------------------------------------------------------------------------
// tb_phase_controller
// Directed bench for phase_controller (CNT_WIDTH=4, WAIT_LIMIT=4).
// A per-cycle vector table covers plain instructions, LOAD stalls, fetch
// stalls, halt handshake, ready-on-limit and the fetch timeout into ERROR;
// hand-written sequences cover reset from ERROR, counter wrap after 16
// instructions and asynchronous reset in the middle of MEMORY.
// ---------------------------------------------------------------------------
module tb_phase_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    phase_controller_if #(.CNT_WIDTH(4)) bus ();

    phase_controller #(
        .CNT_WIDTH (4),
        .WAIT_LIMIT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic       im;
        logic       dm;
        logic       mo;
        logic       hr;
        logic [4:0] ph;
        logic       h;
        logic       e;
        logic [3:0] cyc;
        logic [3:0] ins;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH_F    = 5'b10000;
    localparam logic [4:0] PH_D    = 5'b01000;
    localparam logic [4:0] PH_E    = 5'b00100;
    localparam logic [4:0] PH_M    = 5'b00010;
    localparam logic [4:0] PH_W    = 5'b00001;

    task automatic addVec(input logic im, input logic dm, input logic mo,
                          input logic hr, input logic [4:0] ph,
                          input logic h, input logic e,
                          input int cyc, input int ins);
        vec_t v;
        v.im  = im;
        v.dm  = dm;
        v.mo  = mo;
        v.hr  = hr;
        v.ph  = ph;
        v.h   = h;
        v.e   = e;
        v.cyc = 4'(cyc);
        v.ins = 4'(ins);
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic im, input logic dm,
                                 input logic mo, input logic hr);
        bus.imem_ready = im;
        bus.dmem_ready = dm;
        bus.mem_op     = mo;
        bus.halt_req   = hr;
    endtask

    task automatic checkOutput(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {bus.phase_fetch, bus.phase_decode, bus.phase_execute,
               bus.phase_memory, bus.phase_writeback, bus.halted,
               bus.wait_err, bus.cycle_cnt, bus.instret_cnt};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got ph=%b halted=%b err=%b cyc=%0d ins=%0d, want ph=%b halted=%b err=%b cyc=%0d ins=%0d",
                     name, act[14:10], act[9], act[8], act[7:4], act[3:0],
                     exp[14:10], exp[9], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    initial begin
        // Instruction 1: no waits
        addVec(1, 0, 0, 0, PH_NONE, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, PH_F,    0, 0, 0, 0);
        addVec(1, 0, 0, 0, PH_D,    0, 0, 1, 0);
        addVec(1, 0, 0, 0, PH_E,    0, 0, 2, 0);
        addVec(1, 0, 0, 0, PH_M,    0, 0, 3, 0);
        addVec(1, 0, 0, 0, PH_W,    0, 0, 4, 0);
        // Instruction 2: LOAD, dmem_ready low 3 cycles
        addVec(1, 0, 0, 0, PH_F,    0, 0, 5, 1);
        addVec(1, 0, 1, 0, PH_D,    0, 0, 6, 1);
        addVec(1, 0, 1, 0, PH_E,    0, 0, 7, 1);
        for (int k = 0; k < 3; k++)
            addVec(1, 0, 1, 0, PH_NONE, 0, 0, 8 + k, 1);
        addVec(1, 1, 1, 0, PH_M,    0, 0, 11, 1);
        addVec(1, 0, 0, 0, PH_W,    0, 0, 12, 1);
        // Instruction 3: fetch stall, halt raised in EXECUTE, cycle wrap
        addVec(0, 0, 0, 0, PH_NONE, 0, 0, 13, 2);
        addVec(0, 0, 0, 0, PH_NONE, 0, 0, 14, 2);
        addVec(1, 0, 0, 0, PH_F,    0, 0, 15, 2);
        addVec(1, 0, 0, 0, PH_D,    0, 0, 0, 2);
        addVec(1, 0, 0, 1, PH_E,    0, 0, 1, 2);
        addVec(1, 0, 0, 1, PH_M,    0, 0, 2, 2);
        addVec(1, 0, 0, 1, PH_W,    0, 0, 3, 2);
        for (int k = 0; k < 10; k++)
            addVec(1, 0, 0, 1, PH_NONE, 1, 0, 4, 3);
        addVec(1, 0, 0, 0, PH_NONE, 1, 0, 4, 3);
        // Instruction 4: halt_req ignored outside WRITEBACK, store ready at once
        addVec(1, 0, 0, 1, PH_F,    0, 0, 4, 3);
        addVec(1, 0, 0, 0, PH_D,    0, 0, 5, 3);
        addVec(1, 0, 0, 0, PH_E,    0, 0, 6, 3);
        addVec(1, 1, 1, 0, PH_M,    0, 0, 7, 3);
        addVec(1, 0, 0, 0, PH_W,    0, 0, 8, 3);
        // Instruction 5: ready arrives exactly at the wait limit, both stages
        for (int k = 0; k < 4; k++)
            addVec(0, 0, 0, 0, PH_NONE, 0, 0, 9 + k, 4);
        addVec(1, 0, 0, 0, PH_F,    0, 0, 13, 4);
        addVec(1, 0, 0, 0, PH_D,    0, 0, 14, 4);
        addVec(1, 0, 0, 0, PH_E,    0, 0, 15, 4);
        for (int k = 0; k < 4; k++)
            addVec(1, 0, 1, 0, PH_NONE, 0, 0, k, 4);
        addVec(1, 1, 1, 0, PH_M,    0, 0, 4, 4);
        addVec(1, 0, 0, 0, PH_W,    0, 0, 5, 4);
        // Instruction 6: fetch never ready, ERROR on the 5th edge, then frozen
        for (int k = 0; k < 5; k++)
            addVec(0, 0, 0, 0, PH_NONE, 0, 0, 6 + k, 5);
        for (int k = 0; k < 3; k++)
            addVec(1, 1, 0, 1, PH_NONE, 0, 1, 11, 5);

        applyStimulus(0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        checkOutput("reset", 15'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0)
                @(negedge clk);
            applyStimulus(vecs[i].im, vecs[i].dm, vecs[i].mo, vecs[i].hr);
            #1;
            checkOutput($sformatf("vec%0d", i),
                        {vecs[i].ph, vecs[i].h, vecs[i].e, vecs[i].cyc, vecs[i].ins});
        end

        // Reset is the only way out of ERROR
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("err_reset", 15'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0);
        #1;
        checkOutput("idle_after_err", 15'd0);

        // 16 back-to-back instructions wrap both 4-bit counters
        for (int n = 0; n < 16; n++) begin
            for (int p = 0; p < 5; p++) begin
                @(negedge clk);
                applyStimulus(1, 0, 0, 0);
                #1;
                checkOutput($sformatf("wrap_i%0d_p%0d", n, p),
                            {PH_F >> p, 1'b0, 1'b0, 4'(n * 5 + p), 4'(n)});
            end
        end
        @(negedge clk);
        applyStimulus(1, 0, 1, 0);
        #1;
        checkOutput("wrap_done", {PH_F, 1'b0, 1'b0, 4'd0, 4'd0});

        // Walk a LOAD into MEMORY and reset it asynchronously mid-cycle
        @(negedge clk);
        #1;
        checkOutput("ld_decode", {PH_D, 1'b0, 1'b0, 4'd1, 4'd0});
        @(negedge clk);
        #1;
        checkOutput("ld_execute", {PH_E, 1'b0, 1'b0, 4'd2, 4'd0});
        @(negedge clk);
        #1;
        checkOutput("ld_mem_stall", {PH_NONE, 1'b0, 1'b0, 4'd3, 4'd0});
        #1;
        applyStimulus(1, 1, 1, 0);
        #1;
        checkOutput("ld_mem_ready", {PH_M, 1'b0, 1'b0, 4'd3, 4'd0});
        rst_n = 1'b0;
        #1;
        checkOutput("mid_mem_reset", 15'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0);
        #1;
        checkOutput("idle_after_mem_reset", 15'd0);
        @(negedge clk);
        #1;
        checkOutput("fetch_after_reset", {PH_F, 1'b0, 1'b0, 4'd0, 4'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_controller.md
Name: phase_controller

Overview:
- Multi-cycle sequencer for the RockWave core. Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Drives the one-hot phase enables that gate each stage's output FFs, including phase_decode of the decode block.
- Holds a stage while instruction or data memory is not ready, with a wait-timeout error, and supports a halt handshake.
- Keeps cycle and retired-instruction counters for the CSR block.

Parameters:
CNT_WIDTH, 64, width of cycle_cnt and instret_cnt.
WAIT_LIMIT, 255, max consecutive not-ready cycles tolerated in FETCH or MEMORY before error; must be ≥1.

Ports:
clk  input  1  CPU clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_ready  input  1  instruction memory has valid inst this cycle.
dmem_ready  input  1  data memory access complete this cycle.
mem_op  input  1  current instruction is LOAD or STORE (from decoded_op_de, valid EXECUTE onward).
halt_req  input  1  level request to stop at next instruction boundary.
phase_fetch  output  1  fetch-stage FF enable.
phase_decode  output  1  decode-stage FF enable.
phase_execute  output  1  execute-stage FF enable.
phase_memory  output  1  memory-stage FF enable.
phase_writeback  output  1  writeback/register-file write enable and PC update.
halted  output  1  controller in HALT.
wait_err  output  1  sticky timeout error.
cycle_cnt  output  CNT_WIDTH  cycles spent outside IDLE/HALT/ERROR.
instret_cnt  output  CNT_WIDTH  retired instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, ERROR; registered state, asynchronously reset to IDLE.
- Reset values: state IDLE; all phase_* 0; halted 0; wait_err 0; cycle_cnt 0; instret_cnt 0; wait counter 0.
- Phase outputs are combinational (Mealy) and one-hot; at most one is high per cycle.
  - phase_fetch = FETCH & imem_ready.
  - phase_decode = DECODE.
  - phase_execute = EXECUTE.
  - phase_memory = MEMORY & (~mem_op | dmem_ready).
  - phase_writeback = WRITEBACK.
- Transitions:
  - IDLE→FETCH unconditionally, on the first clock after reset release.
  - FETCH→DECODE when imem_ready; otherwise stay.
  - DECODE→EXECUTE always (1 cycle).
  - EXECUTE→MEMORY always (1 cycle).
  - MEMORY→WRITEBACK when ~mem_op or dmem_ready; otherwise stay.
  - WRITEBACK→HALT if halt_req, else →FETCH.
  - HALT→FETCH on the first cycle halt_req=0.
  - ERROR is terminal until reset.
- Instruction latency: 5 cycles minimum, with no memory wait.
- Wait counter:
  - Increments each cycle in FETCH with imem_ready=0, or in MEMORY with mem_op=1 & dmem_ready=0.
  - Clears on any state change.
  - When the counter equals WAIT_LIMIT and the stall condition is still true: next state ERROR, wait_err set.
  - Ready arriving on the same cycle the counter reaches WAIT_LIMIT: ready wins, normal advance, no error.
- halt_req is sampled only in WRITEBACK. Asserting it mid-instruction never aborts the instruction. halted = (state==HALT).
- mem_op is ignored outside MEMORY.
- Counters:
  - cycle_cnt increments every cycle state ∈ {FETCH..WRITEBACK}.
  - instret_cnt increments on phase_writeback.
  - Both wrap modulo 2^CNT_WIDTH with no saturation or flag.
- Reset asserted mid-instruction: immediate return to IDLE; phases drop to 0 asynchronously through the state; counters cleared.
- In ERROR all phase_* remain 0 and counters freeze.

Test Plan:
- Release reset with imem_ready=1, mem_op=0, halt_req=0 → IDLE 1 cycle, then phase_fetch, decode, execute, memory, writeback each high exactly 1 cycle in order; instret_cnt=1 after cycle 6, cycle_cnt=5.
- LOAD with mem_op=1, dmem_ready low 3 cycles then high → MEMORY lasts 4 cycles; phase_memory high only on 4th; instruction takes 8 cycles; instret_cnt increments once.
- imem_ready held 0 with WAIT_LIMIT=4 → ERROR entered after 4 stall cycles (transition on the 5th edge), wait_err=1, no phase pulses thereafter, counters frozen until rst_n low.
- imem_ready rises exactly on the cycle the wait counter reaches WAIT_LIMIT → DECODE entered, wait_err stays 0.
- halt_req raised during EXECUTE → instruction completes, halted=1 after WRITEBACK; drop halt_req after 10 cycles → FETCH next cycle, cycle_cnt did not advance during HALT.
- CNT_WIDTH=4, run 16 instructions → instret_cnt wraps to 0; rst_n pulsed low mid-MEMORY → all outputs 0 asynchronously, IDLE then FETCH after release.
